// File: rtl/boa_pwr_seq.sv
// ---------------------------------------------------------------------------
// boa_pwr_seq -- power/reset sequencer for the board-level wrappers.
//
// Merges N_EXT debounced external reset requests, a software reset and a
// software shutdown request into one stretched core reset and one core clock
// enable. It also latches a reset-cause vector that firmware can read back.
//
// Optional feature: define BOA_PWR_SEQ_WDT_EN to build in a watchdog that
// counts down in RUN while armed and forces a reset when it expires. Without
// the macro there is no watchdog logic and i_wdt_arm / i_wdt_kick are unused.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low power-on reset
//   i_ext_rst    [N_EXT] raw asynchronous reset requests, active-high
//   i_sw_rst     software reset request, level
//   i_sw_shdn    software shutdown request, level
//   i_wake       resume from shutdown, level
//   i_wdt_arm    watchdog enable (watchdog builds only)
//   i_wdt_kick   watchdog reload pulse (watchdog builds only)
//   o_core_rst   active-high reset to the core
//   o_clk_en     core clock enable, 0 = core clock stopped
//   o_rst_cause  [N_EXT+3] {ext[N_EXT-1:0], watchdog, software, POR}
//   o_state      0 = RESET, 1 = RUN, 2 = SHDN
// ---------------------------------------------------------------------------

`default_nettype none

module boa_pwr_seq #(
    parameter int unsigned N_EXT       = 2,
    parameter int unsigned RST_LEN     = 3,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WDT_CYCLES  = 1000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_EXT-1:0] i_ext_rst,
    input  logic             i_sw_rst,
    input  logic             i_sw_shdn,
    input  logic             i_wake,
    input  logic             i_wdt_arm,
    input  logic             i_wdt_kick,
    output logic             o_core_rst,
    output logic             o_clk_en,
    output logic [N_EXT+2:0] o_rst_cause,
    output logic [1:0]       o_state
);

    localparam int unsigned CAUSE_W = N_EXT + 3;
    localparam int unsigned CNT_W   = $clog2(RST_LEN + 1);
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);

    localparam logic [CNT_W-1:0]   RST_LOAD  = CNT_W'(RST_LEN);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CAUSE_W-1:0] CAUSE_POR = CAUSE_W'(1);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SHDN  = 2'd2;

    // -----------------------------------------------------------------------
    // External inputs: synchroniser chain followed by a debounce filter.
    // The filter output only flips after DEB_CYCLES consecutive synchronised
    // samples disagree with it; any agreeing sample restarts the count.
    // -----------------------------------------------------------------------
    logic [N_EXT-1:0] w_ext_filt;

    for (genvar g = 0; g < N_EXT; g++) begin : g_ext
        logic [SYNC_STAGES-1:0] r_sync;
        logic [DEB_W-1:0]       r_deb_cnt;
        logic                   r_filt;
        logic                   w_sync_out;

        assign w_sync_out = r_sync[SYNC_STAGES-1];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sync    <= '0;
                r_deb_cnt <= '0;
                r_filt    <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], i_ext_rst[g]};
                if (w_sync_out == r_filt) begin
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt == DEB_LAST) begin
                    r_filt    <= w_sync_out;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                end
            end
        end

        assign w_ext_filt[g] = r_filt;
    end

    // -----------------------------------------------------------------------
    // Sequencer state
    // -----------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_core_rst;
    logic               r_clk_en;
    logic [CAUSE_W-1:0] r_cause;

    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_core_rst_nxt;
    logic               w_clk_en_nxt;
    logic [CAUSE_W-1:0] w_cause_nxt;

    logic               w_wdt_fire;
    logic               w_req;
    logic [CAUSE_W-1:0] w_src;

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
`ifdef BOA_PWR_SEQ_WDT_EN
    localparam int unsigned      WDT_W    = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             w_wdt_run;

    assign w_wdt_run = (r_state == ST_RUN) && i_wdt_arm;

    // Fires on the cycle the count would step from 1 to 0, so the core enters
    // RESET exactly WDT_CYCLES cycles after arming or the last kick.
    assign w_wdt_fire = w_wdt_run && !i_wdt_kick && (r_wdt_cnt == WDT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdt_cnt <= WDT_LOAD;
        end else if (r_state == ST_SHDN) begin
            // Frozen while the core clock is stopped.
            r_wdt_cnt <= r_wdt_cnt;
        end else if (!w_wdt_run || i_wdt_kick || w_wdt_fire) begin
            r_wdt_cnt <= WDT_LOAD;
        end else begin
            r_wdt_cnt <= r_wdt_cnt - WDT_W'(1);
        end
    end
`else
    logic w_unused_wdt;

    assign w_unused_wdt = i_wdt_arm ^ i_wdt_kick;
    assign w_wdt_fire   = 1'b0;
`endif

    // Reset sources active this cycle, laid out like the cause vector.
    assign w_src = {w_ext_filt, w_wdt_fire, i_sw_rst, 1'b0};
    assign w_req = (|w_ext_filt) | i_sw_rst | w_wdt_fire;

    // -----------------------------------------------------------------------
    // Next-state logic. Requests beat shutdown and wake in every state.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_core_rst_nxt = r_core_rst;
        w_clk_en_nxt   = r_clk_en;
        w_cause_nxt    = r_cause;

        case (r_state)
            ST_RESET: begin
                w_clk_en_nxt = 1'b1;
                w_cause_nxt  = r_cause | w_src;
                if (w_req) begin
                    w_cnt_nxt = RST_LOAD;
                end else if (r_cnt <= CNT_W'(1)) begin
                    // Last stretch cycle: leave RESET on this edge so core_rst
                    // is high for exactly RST_LEN cycles after the last request.
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_RUN;
                    w_core_rst_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (w_req) begin
                    w_state_nxt    = ST_RESET;
                    w_cnt_nxt      = RST_LOAD;
                    w_core_rst_nxt = 1'b1;
                    w_clk_en_nxt   = 1'b1;
                    w_cause_nxt    = w_src;
                end else if (i_sw_shdn) begin
                    w_state_nxt    = ST_SHDN;
                    w_core_rst_nxt = 1'b0;
                    w_clk_en_nxt   = 1'b0;
                end
            end

            ST_SHDN: begin
                if (w_req) begin
                    w_state_nxt    = ST_RESET;
                    w_cnt_nxt      = RST_LOAD;
                    w_core_rst_nxt = 1'b1;
                    w_clk_en_nxt   = 1'b1;
                    w_cause_nxt    = w_src;
                end else if (i_wake) begin
                    w_state_nxt    = ST_RUN;
                    w_core_rst_nxt = 1'b0;
                    w_clk_en_nxt   = 1'b1;
                end
            end

            default: begin
                // Unreachable encoding: recover through a full reset stretch.
                w_state_nxt    = ST_RESET;
                w_cnt_nxt      = RST_LOAD;
                w_core_rst_nxt = 1'b1;
                w_clk_en_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RESET;
            r_cnt      <= RST_LOAD;
            r_core_rst <= 1'b1;
            r_clk_en   <= 1'b1;
            r_cause    <= CAUSE_POR;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_core_rst <= w_core_rst_nxt;
            r_clk_en   <= w_clk_en_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

    assign o_state     = r_state;
    assign o_core_rst  = r_core_rst;
    assign o_clk_en    = r_clk_en;
    assign o_rst_cause = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_boa_pwr_seq.sv
// Self-checking bench for boa_pwr_seq. Stimulus pushes the output changes it
// expects (with the cycle they must appear on) into a queue; a monitor on the
// falling edge pops and compares whenever any output changes.
module tb_boa_pwr_seq;

    localparam int unsigned N_EXT = 2;
    localparam int unsigned CW    = N_EXT + 3;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_SHDN  = 2'd2;

    typedef struct packed {
        int unsigned   cyc;
        logic [1:0]    st;
        logic          core_rst;
        logic          clk_en;
        logic [CW-1:0] cause;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_EXT-1:0] ext_rst = '0;
    logic             sw_rst = 1'b0;
    logic             sw_shdn = 1'b0;
    logic             wake = 1'b0;
    logic             wdt_arm = 1'b0;
    logic             wdt_kick = 1'b0;
    logic             core_rst;
    logic             clk_en;
    logic [CW-1:0]    rst_cause;
    logic [1:0]       state;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    ev_t         exp_q[$];

    boa_pwr_seq #(
        .N_EXT      (N_EXT),
        .RST_LEN    (3),
        .DEB_CYCLES (4),
        .SYNC_STAGES(2),
        .WDT_CYCLES (10)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_ext_rst  (ext_rst),
        .i_sw_rst   (sw_rst),
        .i_sw_shdn  (sw_shdn),
        .i_wake     (wake),
        .i_wdt_arm  (wdt_arm),
        .i_wdt_kick (wdt_kick),
        .o_core_rst (core_rst),
        .o_clk_en   (clk_en),
        .o_rst_cause(rst_cause),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any change of the output tuple is one observed event.
    logic havep = 1'b0;
    ev_t  prev;
    ev_t  cur;
    ev_t  want;
    always @(negedge clk) begin
        cur.cyc      = cyc;
        cur.st       = state;
        cur.core_rst = core_rst;
        cur.clk_en   = clk_en;
        cur.cause    = rst_cause;
        if (!havep || ({cur.st, cur.core_rst, cur.clk_en, cur.cause} !==
                       {prev.st, prev.core_rst, prev.clk_en, prev.cause})) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change: got cyc=%0d st=%0d core_rst=%b clk_en=%b cause=%b, required no change",
                         cur.cyc, cur.st, cur.core_rst, cur.clk_en, cur.cause);
            end else begin
                want = exp_q.pop_front();
                if (cur !== want) begin
                    n_fail++;
                    $display("FAIL event_%0d: got cyc=%0d st=%0d core_rst=%b clk_en=%b cause=%b, required cyc=%0d st=%0d core_rst=%b clk_en=%b cause=%b",
                             n_tests, cur.cyc, cur.st, cur.core_rst, cur.clk_en, cur.cause,
                             want.cyc, want.st, want.core_rst, want.clk_en, want.cause);
                end
            end
        end
        prev  = cur;
        havep = 1'b1;
    end

    task automatic expect_ev(input int unsigned at, input logic [1:0] st, input logic r,
                             input logic en, input logic [CW-1:0] c);
        ev_t e;
        e.cyc      = at;
        e.st       = st;
        e.core_rst = r;
        e.clk_en   = en;
        e.cause    = c;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset, released after edge 3: RUN three edges later.
        expect_ev(1, S_RESET, 1'b1, 1'b1, 5'b00001);
        step(3);
        rst_n = 1'b1;
        expect_ev(cyc + 3, S_RUN, 1'b0, 1'b1, 5'b00001);
        step(6);

        // Three-cycle pulse on ext_rst[1] is filtered out.
        ext_rst = 2'b10;
        step(3);
        ext_rst = 2'b00;
        step(12);

        // Six-cycle pulse: 2 sync + 4 debounce + 1 FSM edge to RESET; on the
        // way down the filter drops 6 edges after release, RUN 3 edges later.
        ext_rst = 2'b10;
        expect_ev(cyc + 7, S_RESET, 1'b1, 1'b1, 5'b10000);
        step(6);
        ext_rst = 2'b00;
        expect_ev(cyc + 9, S_RUN, 1'b0, 1'b1, 5'b10000);
        step(12);

        // Shutdown then wake, no reset in between.
        sw_shdn = 1'b1;
        expect_ev(cyc + 1, S_SHDN, 1'b0, 1'b0, 5'b10000);
        step(1);
        sw_shdn = 1'b0;
        step(3);
        wake = 1'b1;
        expect_ev(cyc + 1, S_RUN, 1'b0, 1'b1, 5'b10000);
        step(1);
        wake = 1'b0;
        step(3);

        // Shutdown again, then sw_rst and wake together: reset wins.
        sw_shdn = 1'b1;
        expect_ev(cyc + 1, S_SHDN, 1'b0, 1'b0, 5'b10000);
        step(1);
        sw_shdn = 1'b0;
        step(2);
        sw_rst = 1'b1;
        wake   = 1'b1;
        expect_ev(cyc + 1, S_RESET, 1'b1, 1'b1, 5'b00010);
        step(1);
        wake = 1'b0;
        step(3);
        sw_rst = 1'b0;
        expect_ev(cyc + 3, S_RUN, 1'b0, 1'b1, 5'b00010);
        step(6);

        // One-cycle sw_rst, then rst_n pulsed while the stretch counter is 1.
        sw_rst = 1'b1;
        expect_ev(cyc + 1, S_RESET, 1'b1, 1'b1, 5'b00010);
        step(1);
        sw_rst = 1'b0;
        step(2);
        expect_ev(cyc, S_RESET, 1'b1, 1'b1, 5'b00001);
        expect_ev(cyc + 3, S_RUN, 1'b0, 1'b1, 5'b00001);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step(6);

`ifdef BOA_PWR_SEQ_WDT_EN
        // Armed with no kicks: RESET 10 edges after arming.
        wdt_arm = 1'b1;
        expect_ev(cyc + 10, S_RESET, 1'b1, 1'b1, 5'b00100);
        expect_ev(cyc + 13, S_RUN, 1'b0, 1'b1, 5'b00100);
        step(10);
        wdt_arm = 1'b0;
        step(6);

        // Kicked every 8 cycles for over 100 cycles: no reset.
        wdt_arm = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step(7);
            wdt_kick = 1'b1;
            step(1);
            wdt_kick = 1'b0;
        end
        wdt_arm = 1'b0;
        step(3);
`endif

        step(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d expected events never seen, required 0",
                     exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
